// File: rtl/vip_gray_rank_filter.sv
// vip_gray_rank_filter: 3x3 gray rank filter (bypass/median/min/max).
// Three clocks of latency; border pixels are passed through unfiltered.
// Ports: clk, rst (async, active high);
//   per_frame_vsync/href/clken, per_img_Y, filter_mode in;
//   post_frame_vsync/href/clken, post_img_Y out.
module vip_gray_rank_filter #(
  parameter int IMG_HDISP  = 640,
  parameter int IMG_VDISP  = 480,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  per_frame_vsync,
  input  logic                  per_frame_href,
  input  logic                  per_frame_clken,
  input  logic [DATA_WIDTH-1:0] per_img_Y,
  input  logic [1:0]            filter_mode,
  output logic                  post_frame_vsync,
  output logic                  post_frame_href,
  output logic                  post_frame_clken,
  output logic [DATA_WIDTH-1:0] post_img_Y
);
  localparam int CW = $clog2(IMG_HDISP + 1);
  localparam int RW = $clog2(IMG_VDISP + 1);
  localparam int AW = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
  localparam logic [CW-1:0] HMAX = CW'(IMG_HDISP);
  localparam logic [CW-1:0] C1   = CW'(1);
  localparam logic [CW-1:0] C2   = CW'(2);
  localparam logic [RW-1:0] VMAX = RW'(IMG_VDISP);
  localparam logic [RW-1:0] R1   = RW'(1);
  localparam logic [RW-1:0] R2   = RW'(2);

  typedef logic [DATA_WIDTH-1:0] pix_t;

  function automatic pix_t mn(pix_t a, pix_t b);
    return (a < b) ? a : b;
  endfunction
  function automatic pix_t mx(pix_t a, pix_t b);
    return (a > b) ? a : b;
  endfunction
  function automatic pix_t md(pix_t a, pix_t b, pix_t c);
    return mx(mn(a, b), mn(mx(a, b), c));
  endfunction

  logic          vprev_q, lo_seen_q, run_q, hprev_q;
  logic [1:0]    mode_q;
  logic          rise, run, v_g, h_g, ce_g;
  logic          in_rng, we, border;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [AW-1:0] addr;
  pix_t          lb1_q [IMG_HDISP];
  pix_t          lb2_q [IMG_HDISP];
  pix_t          tap1, tap2;

  logic [2:0][DATA_WIDTH-1:0]      cur;
  logic [2:0][1:0][DATA_WIDTH-1:0] win_q;
  logic [2:0][DATA_WIDTH-1:0]      s1_min_d, s1_mid_d, s1_max_d;
  logic [2:0][DATA_WIDTH-1:0]      s1_min_q, s1_mid_q, s1_max_q;

  pix_t       s1_y_q, s2_y_q, y_d;
  logic       s1_byp_q, s2_byp_q;
  logic [1:0] s1_mode_q, s2_mode_q;
  logic [2:0] s1_t_q, s2_t_q;
  pix_t       s2_mxmn_q, s2_mdmd_q, s2_mnmx_q, s2_mnmn_q, s2_mxmx_q;

  // A frame only counts once vsync has been seen low since reset, so a
  // reset released mid-frame stays silent until the next real frame.
  assign rise = per_frame_vsync & ~vprev_q & lo_seen_q;
  assign run  = run_q | rise;
  assign v_g  = per_frame_vsync & run;
  assign h_g  = per_frame_href & run;
  assign ce_g = per_frame_clken & run;

  assign in_rng = col_q < HMAX;
  assign we     = ce_g & h_g & in_rng;
  assign addr   = col_q[AW-1:0];
  assign tap1   = in_rng ? lb1_q[addr] : '0;
  assign tap2   = in_rng ? lb2_q[addr] : '0;
  assign cur    = {per_img_Y, tap1, tap2};
  assign border = ~in_rng | (row_q < R2) | (col_q < C2);

  always_comb begin
    col_d = col_q;
    if (!h_g) col_d = '0;
    else if (ce_g && in_rng) col_d = col_q + C1;
    row_d = row_q;
    if (!v_g) row_d = '0;
    else if (hprev_q && !h_g && row_q < VMAX) row_d = row_q + R1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vprev_q   <= 1'b0;
      lo_seen_q <= 1'b0;
      run_q     <= 1'b0;
      hprev_q   <= 1'b0;
      mode_q    <= 2'b01;
      col_q     <= '0;
      row_q     <= '0;
    end else begin
      vprev_q <= per_frame_vsync;
      hprev_q <= h_g;
      col_q   <= col_d;
      row_q   <= row_d;
      if (!per_frame_vsync) lo_seen_q <= 1'b1;
      if (rise) begin
        run_q  <= 1'b1;
        mode_q <= filter_mode;
      end
    end
  end

  // Line buffers: read-before-write, contents intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      lb1_q[addr] <= per_img_Y;
      lb2_q[addr] <= tap1;
    end
  end

  // Window keeps columns col-2, col-1; column col is taken live.
  always_comb begin
    s1_min_d = '0;
    s1_mid_d = '0;
    s1_max_d = '0;
    for (int r = 0; r < 3; r++) begin
      s1_min_d[r] = mn(mn(win_q[r][0], win_q[r][1]), cur[r]);
      s1_mid_d[r] = md(win_q[r][0], win_q[r][1], cur[r]);
      s1_max_d[r] = mx(mx(win_q[r][0], win_q[r][1]), cur[r]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q     <= '0;
      s1_min_q  <= '0;
      s1_mid_q  <= '0;
      s1_max_q  <= '0;
      s1_y_q    <= '0;
      s1_byp_q  <= 1'b0;
      s1_mode_q <= 2'b00;
      s1_t_q    <= 3'b000;
    end else begin
      if (ce_g && h_g) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= cur[r];
        end
      end
      s1_min_q  <= s1_min_d;
      s1_mid_q  <= s1_mid_d;
      s1_max_q  <= s1_max_d;
      s1_y_q    <= per_img_Y;
      s1_byp_q  <= border;
      s1_mode_q <= mode_q;
      s1_t_q    <= {v_g, h_g, ce_g};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_mxmn_q <= '0;
      s2_mdmd_q <= '0;
      s2_mnmx_q <= '0;
      s2_mnmn_q <= '0;
      s2_mxmx_q <= '0;
      s2_y_q    <= '0;
      s2_byp_q  <= 1'b0;
      s2_mode_q <= 2'b00;
      s2_t_q    <= 3'b000;
    end else begin
      s2_mxmn_q <= mx(mx(s1_min_q[0], s1_min_q[1]), s1_min_q[2]);
      s2_mdmd_q <= md(s1_mid_q[0], s1_mid_q[1], s1_mid_q[2]);
      s2_mnmx_q <= mn(mn(s1_max_q[0], s1_max_q[1]), s1_max_q[2]);
      s2_mnmn_q <= mn(mn(s1_min_q[0], s1_min_q[1]), s1_min_q[2]);
      s2_mxmx_q <= mx(mx(s1_max_q[0], s1_max_q[1]), s1_max_q[2]);
      s2_y_q    <= s1_y_q;
      s2_byp_q  <= s1_byp_q;
      s2_mode_q <= s1_mode_q;
      s2_t_q    <= s1_t_q;
    end
  end

  always_comb begin
    y_d = s2_y_q;
    if (!s2_byp_q) begin
      unique case (s2_mode_q)
        2'b01:   y_d = md(s2_mxmn_q, s2_mdmd_q, s2_mnmx_q);
        2'b10:   y_d = s2_mnmn_q;
        2'b11:   y_d = s2_mxmx_q;
        default: y_d = s2_y_q;
      endcase
    end
    if (!s2_t_q[0]) y_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
      post_img_Y       <= '0;
    end else begin
      post_frame_vsync <= s2_t_q[2];
      post_frame_href  <= s2_t_q[1];
      post_frame_clken <= s2_t_q[0];
      post_img_Y       <= y_d;
    end
  end
endmodule
